shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Command front-end that sits directly upstream of the 64-bit load/enable arithmetic shifter.
- Accepts a shift request over a valid/ready handshake: operand, direction and a 6-bit count.
- Breaks the count into byte-steps (8 bits) followed by bit-steps (1 bit) and drives the shifter's load/ena/amount controls one step per cycle.
- Captures the shifter's q once the sequence finishes and returns it to the requester over a second valid/ready handshake.

Parameters:
- WIDTH, 64, operand width; must equal the shifter width; only 64 is legal.
- CNT_W, 6, shift-count width, log2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  synchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid and in_ready are both high at a clock edge.
- in_data  input  WIDTH  operand.
- in_dir  input  1  0 = logical left, 1 = arithmetic right.
- in_count  input  CNT_W  shift distance, 0..63.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumer ready.
- out_data  output  WIDTH  shifted result.
- busy  output  1  high in every state except IDLE.
- sh_load  output  1  to shifter load.
- sh_ena  output  1  to shifter ena.
- sh_amount  output  2  to shifter amount: 0 = left 1, 1 = left 8, 2 = arith right 1, 3 = arith right 8.
- sh_data  output  WIDTH  to shifter data.
- sh_q  input  WIDTH  from shifter q (registered inside the shifter).

Behaviour:
- Interface decision, fixed: one clock; reset is synchronous and active-low.
- Reset (resetn low at an edge):
  - state becomes IDLE; out_valid=0, out_data=0, busy=0, sh_load=0, sh_ena=0, sh_amount=0, sh_data=0.
  - in_ready=1 from the first cycle after reset.
- States: IDLE, LOAD, STEP8, STEP1, CAPTURE, DONE.
- in_ready is 1 only in IDLE.
- sh_load, sh_ena and sh_amount are decoded from state and registered counters only; they are never combinational from inputs.
- IDLE: on handshake, latch in_data into sh_data, plus dir, n8 = count[5:3] and n1 = count[2:0]. Go to LOAD.
- LOAD: sh_load=1 and sh_ena=0 for exactly one cycle. Next state:
  - STEP8 if n8 != 0;
  - else STEP1 if n1 != 0;
  - else CAPTURE.
- STEP8: sh_ena=1, sh_amount = dir ? 3 : 1. Decrement n8 each cycle. Leave when n8 reaches 0, going to STEP1 if n1 != 0, else CAPTURE.
- STEP1: sh_ena=1, sh_amount = dir ? 2 : 0. Decrement n1 each cycle. Leave when n1 reaches 0, going to CAPTURE.
- CAPTURE: sh_ena=0, sh_load=0. out_data <= sh_q. Go to DONE.
- DONE: out_valid=1. out_data is held stable while out_ready is low. On out_valid && out_ready, go to IDLE. No new request is accepted in that same cycle.
- Latency: with N = count[5:3] + count[2:0] step cycles, out_valid rises N+2 edges after the accept edge.
  - Count 0 gives 2 edges; count 63 gives 16 edges.
- Arithmetic rules:
  - Left shifts fill zeros.
  - Right shifts replicate bit 63; the shifter holds q[63] on right shifts.
  - Result equals in_data << count (left) or $signed(in_data) >>> count (right).
- in_valid, in_data, in_dir and in_count are ignored outside IDLE; no queueing.
- Reset mid-operation: the operation is abandoned. From the next cycle sh_ena=0, sh_load=0, out_valid=0 and no result is produced. The shifter's q content is don't-care.
- sh_data holds the last accepted operand until the next accept; it is not cleared except by reset.
- The shifter is owned exclusively by this block; no other agent drives its controls.

Test Plan:
1. Reset; left, data=0x0000_0000_0000_0001, count=9 -> sh_amount sequence 1, 0 with sh_ena high 2 cycles; out_valid 4 edges after accept; out_data=0x0000_0000_0000_0200.
2. Right, data=0x8000_0000_0000_0000, count=12 -> amounts 3, 2, 2, 2, 2; out_data=0xFFF8_0000_0000_0000; a positive operand 0x7000_0000_0000_0000 with count 12 gives 0x0007_0000_0000_0000.
3. Count=0, data=0xDEAD_BEEF_0123_4567 -> one sh_load pulse, no sh_ena; out_valid 2 edges after accept; out_data equals input.
4. Left, data=0xFFFF_FFFF_FFFF_FFFF, count=63 -> 7 cycles amount 1, then 7 cycles amount 0; out_valid after 16 edges; out_data=0x8000_0000_0000_0000.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, a pending in_valid is not accepted; after the out handshake in_ready=1 and the next request completes correctly.
6. Drive resetn low for one cycle during STEP8 of a count=40 request -> next cycle sh_ena=0, busy=0, in_ready=1; out_valid never rises for the aborted request; a new request then completes correctly.

Source files
------------

// File: rtl/shift_sequencer.sv
// Command front-end for the 64-bit load/enable shifter: breaks a 0..63 shift into
// byte-steps then bit-steps, drives the shifter one step per cycle and returns q.
module shift_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [CNT_W-1:0] in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             sh_load,
    output logic             sh_ena,
    output logic [1:0]       sh_amount,
    output logic [WIDTH-1:0] sh_data,
    input  logic [WIDTH-1:0] sh_q,
    output logic [2:0]       fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and a raised out_valid holds with its data.

    localparam int N8_W = CNT_W - 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        STEP8   = 3'd2,
        STEP1   = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] AMT_L1 = 2'd0;
    localparam logic [1:0] AMT_L8 = 2'd1;
    localparam logic [1:0] AMT_R1 = 2'd2;
    localparam logic [1:0] AMT_R8 = 2'd3;

    state_t          state;
    state_t          state_next;
    logic            dir;
    logic [N8_W-1:0] n8;
    logic [2:0]      n1;
    logic            accept;

    assign accept    = in_valid && in_ready;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            dir      <= 1'b0;
            n8       <= '0;
            n1       <= '0;
            sh_data  <= '0;
            out_data <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh_data <= in_data;
                        dir     <= in_dir;
                        n8      <= in_count[CNT_W-1:3];
                        n1      <= in_count[2:0];
                    end
                end
                STEP8:   n8       <= n8 - 1'b1;
                STEP1:   n1       <= n1 - 1'b1;
                CAPTURE: out_data <= sh_q;
                default: ;
            endcase
        end
    end

    // Shifter controls come only from state and the registered step counters.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        sh_load    = 1'b0;
        sh_ena     = 1'b0;
        sh_amount  = AMT_L1;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                sh_load = 1'b1;
                if (n8 != '0) begin
                    state_next = STEP8;
                end else if (n1 != '0) begin
                    state_next = STEP1;
                end else begin
                    state_next = CAPTURE;
                end
            end
            STEP8: begin
                sh_ena    = 1'b1;
                sh_amount = dir ? AMT_R8 : AMT_L8;
                // Last byte-step is the one that brings n8 to zero.
                if (n8 == N8_W'(1)) begin
                    state_next = (n1 != '0) ? STEP1 : CAPTURE;
                end
            end
            STEP1: begin
                sh_ena    = 1'b1;
                sh_amount = dir ? AMT_R1 : AMT_L1;
                if (n1 == 3'd1) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural model of the downstream
// shifter; checks step sequences, latency, results, backpressure and mid-run reset.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_dir;
    logic [5:0]  in_count;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic        sh_load;
    logic        sh_ena;
    logic [1:0]  sh_amount;
    logic [63:0] sh_data;
    logic [63:0] sh_q = '0;
    logic [2:0]  fsm_state;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [1:0]  amt_q[$];

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(64), .CNT_W(6)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .sh_load   (sh_load),
        .sh_ena    (sh_ena),
        .sh_amount (sh_amount),
        .sh_data   (sh_data),
        .sh_q      (sh_q),
        .fsm_state (fsm_state)
    );

    // Downstream shifter: q registered, load wins over ena.
    always @(posedge clk) begin
        if (sh_load) begin
            sh_q <= sh_data;
        end else if (sh_ena) begin
            case (sh_amount)
                2'd0: sh_q <= sh_q << 1;
                2'd1: sh_q <= sh_q << 8;
                2'd2: sh_q <= $signed(sh_q) >>> 1;
                default: sh_q <= $signed(sh_q) >>> 8;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic run_req(input logic [63:0] data, input logic dir, input logic [5:0] cnt,
                           input logic [63:0] exp, input int hold);
        int n;
        int edges;
        int steps;
        bit seen;
        logic [63:0] held;
        n = int'(cnt[5:3]) + int'(cnt[2:0]);
        exp_q.push_back(exp);
        amt_q.delete();
        for (int i = 0; i < int'(cnt[5:3]); i++) amt_q.push_back(dir ? 2'd3 : 2'd1);
        for (int i = 0; i < int'(cnt[2:0]); i++) amt_q.push_back(dir ? 2'd2 : 2'd0);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_data   = data;
        in_dir    = dir;
        in_count  = cnt;
        check("req_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_dir   = ~dir;
        in_count = 6'($urandom_range(0, 63));
        check("load_pulse", 64'({sh_ena, sh_load}), 64'b01);
        check("sh_data", sh_data, data);
        edges = 0;
        steps = 0;
        seen  = 0;
        while (!seen && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (out_valid) begin
                seen = 1;
            end else if (sh_ena) begin
                steps++;
                if (amt_q.size() > 0) check("amount", 64'(sh_amount), 64'(amt_q.pop_front()));
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(edges), 64'(n + 2));
        check("step_count", 64'(steps), 64'(n));
        if (seen) begin
            if (hold > 0) begin
                held     = out_data;
                in_valid = 1'b1;
                in_data  = ~data;
                in_count = 6'd1;
                for (int i = 0; i < hold; i++) begin
                    @(posedge clk); #1;
                    check("bp_valid", 64'(out_valid), 64'd1);
                    check("bp_data", out_data, held);
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                end
                out_ready = 1'b1;
            end
            check("out_data", out_data, exp_q.pop_front());
            @(posedge clk); #1;
            check("post_valid", 64'(out_valid), 64'd0);
            check("post_busy", 64'(busy), 64'd0);
            check("post_in_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            exp_q.delete();
        end
    endtask

    initial begin
        int ovs;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dir    = 1'b0;
        in_count  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        check("rst_state", 64'(fsm_state), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ctrl", 64'({sh_load, sh_ena, sh_amount}), 64'd0);
        check("rst_sh_data", sh_data, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        run_req(64'h0000_0000_0000_0001, 1'b0, 6'd9,  64'h0000_0000_0000_0200, 0);
        run_req(64'h8000_0000_0000_0000, 1'b1, 6'd12, 64'hFFF8_0000_0000_0000, 0);
        run_req(64'h7000_0000_0000_0000, 1'b1, 6'd12, 64'h0007_0000_0000_0000, 0);
        run_req(64'hDEAD_BEEF_0123_4567, 1'b0, 6'd0,  64'hDEAD_BEEF_0123_4567, 0);
        run_req(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'd63, 64'h8000_0000_0000_0000, 0);
        run_req(64'h0123_4567_89AB_CDEF, 1'b0, 6'd8,  64'h2345_6789_ABCD_EF00, 0);
        run_req(64'h8000_0000_0000_0001, 1'b1, 6'd7,  64'hFF00_0000_0000_0000, 0);
        run_req(64'h0000_0000_0000_00F0, 1'b0, 6'd4,  64'h0000_0000_0000_0F00, 5);
        run_req(64'h1234_5678_9ABC_DEF0, 1'b1, 6'd16, 64'h0000_1234_5678_9ABC, 0);

        // Abort a count=40 request while it is in its byte-steps.
        in_valid = 1'b1;
        in_data  = 64'hA5A5_A5A5_A5A5_A5A5;
        in_dir   = 1'b0;
        in_count = 6'd40;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_in_step8", 64'({sh_ena, sh_amount}), 64'b101);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check("abort_ena", 64'(sh_ena), 64'd0);
        check("abort_load", 64'(sh_load), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_sh_data", sh_data, 64'd0);
        ovs = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) ovs++;
        end
        check("abort_no_result", 64'(ovs), 64'd0);
        run_req(64'h0000_0000_0000_0003, 1'b0, 6'd40, 64'h0000_0300_0000_0000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
